// File: rtl/ifetch_ctrl.sv
// ---------------------------------------------------------------------------
// ifetch_ctrl -- instruction fetch front end.
//
// Issues sequential word reads to a one-cycle-latency instruction memory,
// buffers the returned words in a 2-entry {pc, instr} FIFO and presents the
// FIFO head to decode with a valid/ready handshake. A redirect flushes the
// FIFO, drops any response returning that cycle and immediately fetches the
// new target.
//
// Ports
//   clk             clock, all state changes on its rising edge
//   rst             asynchronous active-high reset
//   imem_en         read request to instruction memory this cycle
//   imem_addr       byte address of the request (valid when imem_en=1)
//   imem_rdata      read data, one cycle after the matching request
//   redirect_valid  branch/jump/trap redirect request
//   redirect_pc     redirect target (bits [1:0] ignored)
//   out_valid       instruction available to decode
//   out_ready       decode accepts the instruction
//   out_instr       instruction at the FIFO head
//   out_pc          byte address of out_instr
// ---------------------------------------------------------------------------
module ifetch_ctrl #(
  parameter int PC_WIDTH = 32,
  parameter int I_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_en,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [I_WIDTH-1:0]  imem_rdata,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [I_WIDTH-1:0]  out_instr,
  output logic [PC_WIDTH-1:0] out_pc
);

  logic [PC_WIDTH-1:0] fetch_pc_p0;
  logic                vld_p1;
  logic [PC_WIDTH-1:0] pc_p1;
  logic [1:0]          count_p2;
  logic [PC_WIDTH-1:0] fifo_pc_p2    [2];
  logic [I_WIDTH-1:0]  fifo_instr_p2 [2];

  logic                pop;
  logic                push;
  logic                seq_issue;
  logic [1:0]          occ_next;
  logic [1:0]          wr_slot;
  logic [PC_WIDTH-1:0] redirect_addr;

  function automatic logic [PC_WIDTH-1:0] word_align(input logic [PC_WIDTH-1:0] a);
    return {a[PC_WIDTH-1:2], 2'b00};
  endfunction

  assign redirect_addr = word_align(redirect_pc);

  // Decode handshake; the head is hidden while a redirect is flushing it.
  assign out_valid = !rst && (count_p2 != 2'd0) && !redirect_valid;
  assign pop       = out_valid && out_ready;
  assign push      = vld_p1 && !redirect_valid;

  // Entries that will be held next cycle if nothing new is issued. Never
  // exceeds 2, so issuing only when it is below 2 keeps the FIFO from
  // overflowing once the new request returns.
  assign occ_next  = count_p2 + {1'b0, vld_p1} - {1'b0, pop};
  assign seq_issue = (occ_next < 2'd2);
  assign wr_slot   = count_p2 - {1'b0, pop};

  assign imem_en   = !rst && (redirect_valid || seq_issue);
  assign imem_addr = redirect_valid ? redirect_addr : fetch_pc_p0;

  assign out_instr = rst ? '0 : fifo_instr_p2[0];
  assign out_pc    = rst ? '0 : fifo_pc_p2[0];

  // ---- stage p0 -> p1 : request issue, fetch PC and in-flight tracking ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_p0 <= RESET_PC;
      vld_p1      <= 1'b0;
      count_p2    <= 2'd0;
    end else if (redirect_valid) begin
      fetch_pc_p0 <= redirect_addr + PC_WIDTH'(4);
      vld_p1      <= 1'b1;
      count_p2    <= 2'd0;
    end else begin
      if (seq_issue) begin
        fetch_pc_p0 <= fetch_pc_p0 + PC_WIDTH'(4);
      end
      vld_p1   <= seq_issue;
      count_p2 <= occ_next;
    end
  end

  always_ff @(posedge clk) begin
    if (imem_en) begin
      pc_p1 <= imem_addr;
    end
  end

  // ---- stage p1 -> p2 : response capture into the FIFO ----
  // Shift on pop first; a push landing in slot 0 in the same cycle overrides.
  always_ff @(posedge clk) begin
    if (pop) begin
      fifo_pc_p2[0]    <= fifo_pc_p2[1];
      fifo_instr_p2[0] <= fifo_instr_p2[1];
    end
    if (push) begin
      fifo_pc_p2[wr_slot[0]]    <= pc_p1;
      fifo_instr_p2[wr_slot[0]] <= imem_rdata;
    end
  end

endmodule
